// File: rtl/noc_input_controller.sv
// Input-port flow control: moves one flit from the upstream FIFO into the single-flit buffer
// using a read strobe, then a write strobe. Define INPUT_CTRL_STATS_EN to add the xfer_count port.
module noc_input_controller #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             input_empty,
    input  logic             buffer_empty,
    output logic             input_read,
`ifdef INPUT_CTRL_STATS_EN
    output logic [CNT_W-1:0] xfer_count,
`endif
    output logic             buffer_write
);

    typedef enum logic [2:0] {
        IDLE  = 3'b001,
        READ  = 3'b010,
        WRITE = 3'b100
    } state_t;

    state_t state;

    if (CNT_W < 1) begin : g_cnt_w_check
        $error("CNT_W must be at least 1");
    end

    // One-hot state bits drive the strobes directly, so no input reaches an output combinationally.
    assign input_read   = state[1];
    assign buffer_write = state[2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (!input_empty && buffer_empty) state <= READ;
                READ:    state <= WRITE;
                WRITE:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef INPUT_CTRL_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            xfer_count <= '0;
        end else if (state == WRITE) begin
            xfer_count <= xfer_count + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_noc_input_controller.sv
// Self-checking bench for noc_input_controller: constant vector table, hand-written reset and
// counter sequences, and random stimulus against an edge-timing reference model.
module tb_noc_input_controller;

    logic clk = 1'b0;
    logic reset;
    logic input_empty;
    logic buffer_empty;
    logic input_read;
    logic buffer_write;
`ifdef INPUT_CTRL_STATS_EN
    logic [1:0] xfer_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: edge index, index of the last start edge, first edge a start may occur.
    int e_idx     = 0;
    int last_st   = -10;
    int next_free = 1;
    int cnt_m     = 0;

    always #5 clk = ~clk;

    noc_input_controller #(.CNT_W(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .input_empty  (input_empty),
        .buffer_empty (buffer_empty),
        .input_read   (input_read),
`ifdef INPUT_CTRL_STATS_EN
        .xfer_count   (xfer_count),
`endif
        .buffer_write (buffer_write)
    );

    typedef struct {
        logic ie;
        logic be;
        logic rd;
        logic wr;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_count(input string name, input int exp);
`ifdef INPUT_CTRL_STATS_EN
        chk(name, {30'd0, xfer_count}, exp);
`endif
    endtask

    // Drive inputs, take one rising edge, advance the model, then compare at edge + 1.
    task automatic cyc(input logic ie, input logic be, input string name);
        logic exp_rd;
        logic exp_wr;
        input_empty  = ie;
        buffer_empty = be;
        @(posedge clk);
        e_idx++;
        if (!reset) begin
            last_st   = -10;
            next_free = e_idx + 1;
            cnt_m     = 0;
        end else begin
            if (e_idx >= next_free && !ie && be) begin
                last_st   = e_idx;
                next_free = e_idx + 3;
            end
            if (e_idx == last_st + 2) cnt_m = (cnt_m + 1) % 4;
        end
        exp_rd = (e_idx == last_st);
        exp_wr = (e_idx == last_st + 1);
        #1;
        chk({name, " rd"}, {31'd0, input_read}, {31'd0, exp_rd});
        chk({name, " wr"}, {31'd0, buffer_write}, {31'd0, exp_wr});
        check_count({name, " cnt"}, cnt_m);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cyc(1'b0, 1'b1, "rst");
        cyc(1'b0, 1'b1, "rst");
        reset = 1'b1;
    endtask

    vec_t vecs[$];
    int   wrap_exp[5] = '{1, 2, 3, 0, 1};

    initial begin
        reset        = 1'b0;
        input_empty  = 1'b0;
        buffer_empty = 1'b1;
        #1;
        chk("async reset rd", {31'd0, input_read}, 32'd0);
        chk("async reset wr", {31'd0, buffer_write}, 32'd0);
        check_count("async reset cnt", 0);

        // Reset held with start condition true: strobes stay low.
        do_reset();

        // Sustained, blocking, single transfer, inputs changing mid-transfer.
        vecs = '{
            '{1'b0, 1'b1, 1'b1, 1'b0}, '{1'b0, 1'b1, 1'b0, 1'b1},
            '{1'b0, 1'b1, 1'b0, 1'b0}, '{1'b0, 1'b1, 1'b1, 1'b0},
            '{1'b1, 1'b1, 1'b0, 1'b1}, '{1'b1, 1'b1, 1'b0, 1'b0},
            '{1'b1, 1'b1, 1'b0, 1'b0}, '{1'b1, 1'b1, 1'b0, 1'b0},
            '{1'b1, 1'b0, 1'b0, 1'b0}, '{1'b1, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b0, 1'b0, 1'b0}, '{1'b0, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b1, 1'b0}, '{1'b1, 1'b1, 1'b0, 1'b1},
            '{1'b1, 1'b0, 1'b0, 1'b0}, '{1'b0, 1'b1, 1'b1, 1'b0},
            '{1'b1, 1'b0, 1'b0, 1'b1}, '{1'b0, 1'b1, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b1, 1'b0}, '{1'b1, 1'b1, 1'b0, 1'b1},
            '{1'b1, 1'b1, 1'b0, 1'b0}
        };
        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].ie, vecs[i].be, "model");
            chk($sformatf("vec%0d rd", i), {31'd0, input_read}, {31'd0, vecs[i].rd});
            chk($sformatf("vec%0d wr", i), {31'd0, buffer_write}, {31'd0, vecs[i].wr});
        end
        check_count("table total cnt", 1);

        // Asynchronous reset while in READ: strobe drops at once, no write follows.
        do_reset();
        cyc(1'b0, 1'b1, "pre-abort");
        chk("abort in READ", {31'd0, input_read}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("abort rd drop", {31'd0, input_read}, 32'd0);
        chk("abort wr", {31'd0, buffer_write}, 32'd0);
        cyc(1'b0, 1'b1, "abort held");
        reset = 1'b1;
        cyc(1'b1, 1'b1, "after abort");
        chk("after abort wr", {31'd0, buffer_write}, 32'd0);

        // Counter wrap with a 2-bit counter over five transfers.
        do_reset();
        for (int t = 0; t < 5; t++) begin
            cyc(1'b0, 1'b1, "wrap");
            cyc(1'b1, 1'b1, "wrap");
            cyc(1'b1, 1'b1, "wrap");
            check_count($sformatf("wrap xfer%0d", t), wrap_exp[t]);
        end

        // Random stimulus against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
